// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : Scans a 4x4 active-low key matrix one column at a time.
//                The column pattern rotates the same way as the 7-seg digit
//                anodes. Row samples are debounced over whole scans, and a
//                single debounced key is reported as a code plus press pulse.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                row[3:0]  - matrix rows, active-low, asynchronous to clk
//                col[3:0]  - column drive, one-hot active-low
//                key_code  - accepted key, col_idx*4 + row_idx
//                key_valid - one-cycle pulse on a newly accepted press
//                key_held  - high while the accepted key is considered down
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scan #(
  parameter int SCAN_DIV       = 4,   // clk cycles per column, 4..65535
  parameter int DEBOUNCE_SCANS = 3    // full scans to accept press/release, 2..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [15:0] c_div_last  = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  c_db_target = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } state_t;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_col;
  logic [1:0]  r_col_idx;
  logic [15:0] r_snapshot;
  state_t      r_state;
  logic [3:0]  r_stab_cnt;
  logic [3:0]  r_cand;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_held;

  logic [3:0]  w_row_hit;
  logic        w_tick;
  logic        w_scan_done;
  logic [15:0] w_image;
  logic [4:0]  w_hits;
  logic [3:0]  w_hit_idx;
  logic        w_one;
  logic [3:0]  w_stab_next;

  // Synchronised rows, inverted so a pressed key reads as 1.
  assign w_row_hit   = ~r_sync2;
  assign w_tick      = (r_div_cnt == c_div_last);
  assign w_scan_done = w_tick && (r_col_idx == 2'd3);
  assign w_stab_next = r_stab_cnt + 4'd1;

  // Full 16-bit image of this scan: the last column has not been written into
  // the snapshot yet when the scan completes, so merge the live sample here.
  always_comb begin
    w_image = r_snapshot;
    w_image[{r_col_idx, 2'b00} +: 4] = w_row_hit;
  end

  // Population count plus index of the (last) set bit; the index only matters
  // when exactly one bit is set.
  always_comb begin
    w_hits    = 5'd0;
    w_hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_image[i]) begin
        w_hits    = w_hits + 5'd1;
        w_hit_idx = 4'(i);
      end
    end
  end

  assign w_one = (w_hits == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_div_cnt   <= 16'd0;
      r_col       <= 4'b1110;
      r_col_idx   <= 2'd0;
      r_snapshot  <= 16'd0;
      r_state     <= ST_IDLE;
      r_stab_cnt  <= 4'd0;
      r_cand      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= row;
      r_sync2     <= r_sync1;
      r_key_valid <= 1'b0;

      if (w_tick) begin
        r_div_cnt                         <= 16'd0;
        r_snapshot[{r_col_idx, 2'b00} +: 4] <= w_row_hit;
        r_col                             <= {r_col[2:0], r_col[3]};
        r_col_idx                         <= r_col_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end

      if (w_scan_done) begin
        case (r_state)
          ST_IDLE: begin
            if (w_one) begin
              r_cand     <= w_hit_idx;
              r_stab_cnt <= 4'd1;
              r_state    <= ST_DB_PRESS;
            end
          end
          ST_DB_PRESS: begin
            if (w_one && (w_hit_idx == r_cand)) begin
              r_stab_cnt <= w_stab_next;
              if (w_stab_next == c_db_target) begin
                r_key_code  <= r_cand;
                r_key_held  <= 1'b1;
                r_key_valid <= 1'b1;
                r_state     <= ST_HELD;
              end
            end else if (w_one) begin
              r_cand     <= w_hit_idx;
              r_stab_cnt <= 4'd1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (!(w_one && (w_hit_idx == r_key_code))) begin
              r_stab_cnt <= 4'd1;
              r_state    <= ST_DB_REL;
            end
          end
          ST_DB_REL: begin
            // A bounce back to the held key resumes holding without a new pulse;
            // anything else (none, other key, ghosting) counts toward release.
            if (w_one && (w_hit_idx == r_key_code)) begin
              r_state <= ST_HELD;
            end else begin
              r_stab_cnt <= w_stab_next;
              if (w_stab_next == c_db_target) begin
                r_key_held <= 1'b0;
                r_state    <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire
